// File: rtl/recepcao_serial_face.sv
// Serial face receiver: 8N1 bytes -> 16-bit pixel words -> 3x3 buffer with a registered
// line/column read port. Flags a complete face and sticky framing errors.
module recepcao_serial_face #(
  parameter int CLKS_PER_BIT = 434,
  parameter int LINES        = 3,
  parameter int COLUMNS      = 3,
  parameter int S_DATA       = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              entrada_serial,
  input  logic              habilita,
  input  logic [1:0]        addr_linha,
  input  logic [1:0]        addr_coluna,
  output logic [S_DATA-1:0] q,
  output logic              face_pronta,
  output logic              recebendo,
  output logic              erro_quadro,
  output logic [3:0]        db_estado
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] T_FULL = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] T_HALF = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [1:0]    L_MAX  = 2'(LINES - 1);
  localparam logic [1:0]    C_MAX  = 2'(COLUMNS - 1);

  typedef enum logic [1:0] {OCIOSO, INICIO, DADOS, PARADA} rx_t;
  typedef enum logic [1:0] {ESPERA, CAPTURA, COMPLETA} cap_t;

  // ---------------- input synchronizer (idle-high reset value) ----------------
  logic [1:0] sync;
  logic       rx_s;

  always_ff @(posedge clock) begin
    if (!reset) sync <= 2'b11;
    else        sync <= {sync[0], entrada_serial};
  end
  assign rx_s = sync[1];

  // ---------------- RX FSM ----------------
  rx_t           rx_st, rx_nx;
  logic [TW-1:0] tmr;
  logic [2:0]    nbit;
  logic [7:0]    rx_byte;
  logic          tmr_clr, sample_bit, stop_ok, stop_bad;
  logic          byte_ok, frame_err;

  always_ff @(posedge clock) begin
    if (!reset) rx_st <= OCIOSO;
    else        rx_st <= rx_nx;
  end

  always_comb begin
    rx_nx      = rx_st;
    tmr_clr    = 1'b0;
    sample_bit = 1'b0;
    stop_ok    = 1'b0;
    stop_bad   = 1'b0;
    case (rx_st)
      OCIOSO: if (!rx_s) begin
        rx_nx   = INICIO;
        tmr_clr = 1'b1;
      end
      INICIO: if (tmr == T_HALF) begin
        tmr_clr = 1'b1;
        rx_nx   = rx_s ? OCIOSO : DADOS;   // high at mid-start is a glitch
      end
      DADOS: if (tmr == T_FULL) begin
        tmr_clr    = 1'b1;
        sample_bit = 1'b1;
        if (nbit == 3'd7) rx_nx = PARADA;
      end
      PARADA: if (tmr == T_FULL) begin
        tmr_clr  = 1'b1;
        rx_nx    = OCIOSO;
        stop_ok  = rx_s;
        stop_bad = !rx_s;
      end
      default: rx_nx = OCIOSO;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      tmr       <= '0;
      nbit      <= '0;
      rx_byte   <= '0;
      byte_ok   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      tmr       <= tmr_clr ? '0 : tmr + 1'b1;
      byte_ok   <= stop_ok;
      frame_err <= stop_bad;
      if (rx_st == OCIOSO) nbit <= '0;
      if (sample_bit) begin
        rx_byte <= {rx_s, rx_byte[7:1]};
        nbit    <= nbit + 1'b1;
      end
    end
  end

  // ---------------- capture FSM ----------------
  cap_t              cap_st, cap_nx;
  logic [1:0]        linha, coluna;
  logic              fase, wr_pend, wr_en, restart, last;
  logic [7:0]        hi;
  logic [S_DATA-1:0] wr_data;

  assign last = (linha == L_MAX) && (coluna == C_MAX);

  always_ff @(posedge clock) begin
    if (!reset) cap_st <= ESPERA;
    else        cap_st <= cap_nx;
  end

  // A restart also cancels a word still waiting to be written.
  always_comb begin
    cap_nx  = cap_st;
    restart = 1'b0;
    wr_en   = 1'b0;
    case (cap_st)
      ESPERA: if (habilita) begin
        restart = 1'b1;
        cap_nx  = CAPTURA;
      end
      CAPTURA: begin
        if (habilita) restart = 1'b1;
        else if (wr_pend) begin
          wr_en = 1'b1;
          if (last) cap_nx = COMPLETA;
        end
      end
      COMPLETA: if (habilita) begin
        restart = 1'b1;
        cap_nx  = CAPTURA;
      end
      default: cap_nx = ESPERA;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      linha       <= '0;
      coluna      <= '0;
      fase        <= 1'b0;
      hi          <= '0;
      wr_data     <= '0;
      wr_pend     <= 1'b0;
      erro_quadro <= 1'b0;
    end else begin
      if (restart) begin
        linha       <= '0;
        coluna      <= '0;
        fase        <= 1'b0;
        wr_pend     <= 1'b0;
        erro_quadro <= 1'b0;
      end else if (cap_st == CAPTURA) begin
        wr_pend <= 1'b0;
        if (wr_en) begin
          if (coluna == C_MAX) begin
            coluna <= '0;
            linha  <= last ? 2'd0 : linha + 1'b1;
          end else begin
            coluna <= coluna + 1'b1;
          end
        end
        if (frame_err) fase <= 1'b0;
        else if (byte_ok) begin
          if (!fase) begin
            hi   <= rx_byte;
            fase <= 1'b1;
          end else begin
            wr_data <= {hi, rx_byte};
            wr_pend <= 1'b1;
            fase    <= 1'b0;
          end
        end
      end
      if (frame_err) erro_quadro <= 1'b1;
    end
  end

  // ---------------- buffer and read port ----------------
  logic [LINES-1:0][COLUMNS-1:0][S_DATA-1:0] mem;

  always_ff @(posedge clock) begin
    if (!reset)     mem <= '0;
    else if (wr_en) mem[linha][coluna] <= wr_data;
  end

  always_ff @(posedge clock) begin
    if (!reset) q <= '0;
    else if (addr_linha <= L_MAX && addr_coluna <= C_MAX) q <= mem[addr_linha][addr_coluna];
    else q <= '0;
  end

  assign face_pronta = (cap_st == COMPLETA);
  assign recebendo   = (cap_st == CAPTURA);
  assign db_estado   = {cap_st, rx_st};

endmodule

// File: doc/recepcao_serial_face.md
Name: recepcao_serial_face

Overview:
Upstream stage of the serial transmission datapath. Receives one cube face (3x3 pixels, 16 bits each) from the serial line as 8N1 bytes and assembles byte pairs into pixel words. Stores the words in an internal 3x3 buffer and exposes a line/column read port with the same addressing the transmitter's counters drive. Signals when a complete face has been captured.

Parameters:
CLKS_PER_BIT, 434, clock cycles per serial bit (50 MHz / 115200 baud); minimum 4.
LINES, 3, buffer lines.
COLUMNS, 3, buffer columns.
S_DATA, 16, pixel word width; fixed at 2 bytes.

Ports:
clock  in  1  system clock, all logic on rising edge.
reset  in  1  synchronous, active-low reset.
entrada_serial  in  1  asynchronous serial line, idle high.
habilita  in  1  one-cycle pulse; arms or re-arms a face capture.
addr_linha  in  2  read line address.
addr_coluna  in  2  read column address.
q  out  16  registered read data.
face_pronta  out  1  level; all 9 words written.
recebendo  out  1  high while capture is armed and incomplete.
erro_quadro  out  1  sticky stop-bit error flag.
db_estado  out  4  debug: {capture state[1:0], rx state[1:0]}.

Behaviour:
- Reset (reset=0 at a clock edge):
  - Both FSMs return to idle. Line/column counters and byte phase are cleared.
  - q=0, face_pronta=0, recebendo=0, erro_quadro=0, db_estado=0.
  - Buffer contents are cleared to 0.
  - Reset wins over every other input, including mid-byte.
- Input synchronizer: entrada_serial passes through 2 flip-flops. All RX decisions use the synchronized value, which adds 2 cycles of latency.
- RX FSM states: OCIOSO, INICIO, DADOS, PARADA.
  - OCIOSO: a synchronized low level moves to INICIO and loads the bit timer.
  - INICIO: after CLKS_PER_BIT/2 cycles (integer division), the line is resampled. Low goes to DADOS. High is a glitch: return to OCIOSO and produce no byte.
  - DADOS: 8 samples taken every CLKS_PER_BIT cycles at mid-bit, LSB first.
  - PARADA: one more CLKS_PER_BIT later the stop bit is sampled. High gives byte_ok for 1 cycle. Low sets erro_quadro and discards the byte. Either way, return to OCIOSO.
  - The RX FSM runs regardless of capture state.
- Capture FSM states: ESPERA, CAPTURA, COMPLETA.
  - ESPERA: byte_ok is ignored. habilita moves to CAPTURA and clears the counters, byte phase and erro_quadro.
  - CAPTURA: recebendo=1.
    - Phase 0 byte goes to the high byte register.
    - Phase 1 byte forms word {high, byte}. The word is written at (linha, coluna) on the cycle after byte_ok.
    - After each write, coluna increments. Wrap COLUMNS-1 -> 0 increments linha.
    - The write at (LINES-1, COLUMNS-1) moves to COMPLETA.
  - COMPLETA: face_pronta=1 and recebendo=0. Further bytes are ignored. habilita re-arms to CAPTURA and clears face_pronta.
  - habilita during CAPTURA restarts the capture: counters, byte phase and erro_quadro are cleared. Buffer contents are kept and will be overwritten.
  - habilita coincident with byte_ok: the restart wins and the byte is dropped.
- Framing error during CAPTURA: byte phase returns to 0, so a pending high byte is discarded. Line/column counters are unchanged.
- Read port:
  - q <= mem[addr_linha][addr_coluna] every cycle, giving 1-cycle latency.
  - Address 3 on either axis returns 0.
  - Write and read of the same address in the same cycle: q shows the old value; the new value appears on the next cycle.
- Buffer write happens only inside this block; there is no external write port.

Test Plan:
1. Reset: hold reset=0 for 3 cycles with random entrada_serial -> q=0, face_pronta=0, recebendo=0, erro_quadro=0, db_estado=0. Every address reads 0.
2. Full face, CLKS_PER_BIT=8: pulse habilita, then send bytes 0xA0,0x00, 0xA0,0x01, ..., 0xA0,0x08 -> face_pronta rises after the 18th stop bit. Reading (l,c) gives 0xA000+3l+c one cycle after the address is applied. Address (3,0) gives 0.
3. Framing error: after an armed high byte 0x12, send 0x34 with stop bit 0, then bytes 0x56,0x78 -> erro_quadro=1 and (0,0)=0x5678. Pulse habilita -> erro_quadro=0.
4. Start glitch: drive entrada_serial low for 2 cycles (CLKS_PER_BIT=8) -> RX returns to OCIOSO, no byte is produced, and the counters are unchanged.
5. Pre-arm and post-complete bytes: send 4 bytes before habilita, then a full face, then 2 extra bytes -> only the face words are stored, and face_pronta stays 1.
6. Restart: after 5 words, pulse habilita and send 0xFF,0xFF -> (0,0)=0xFFFF, (0,1) keeps its earlier value, and recebendo=1. Reset asserted mid-byte -> all outputs return to their reset values.
